// File: rtl/cmd_proto_pkg.sv
// Shared command-protocol definitions: opcode/bit characters, FSM state
// encodings and small opcode classification helpers.
package cmd_proto_pkg;

  localparam logic [7:0] OP_R = "r";
  localparam logic [7:0] OP_S = "s";
  localparam logic [7:0] OP_G = "g";
  localparam logic [7:0] OP_I = "i";
  localparam logic [7:0] OP_O = "o";
  localparam logic [7:0] OP_E = "e";
  localparam logic [7:0] OP_F = "f";
  localparam logic [7:0] OP_P = "p";

  localparam logic [7:0] CH_0 = "0";
  localparam logic [7:0] CH_1 = "1";

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_CHI,
    SEND_CLO,
    SEND_BITS,
    RECV_BITS,
    DONE
  } cmd_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_START,
    HS_BUSY
  } hs_state_e;

  // Opcode byte only, no count follows
  function automatic logic op_single(input logic [7:0] op);
    return (op == OP_R) || (op == OP_F) || (op == OP_P);
  endfunction

  // Count bounded by MAXBITS
  function automatic logic op_bitcount(input logic [7:0] op);
    return (op == OP_S) || (op == OP_G) || (op == OP_I) || (op == OP_O);
  endfunction

  // Payload bits transmitted after the count
  function automatic logic op_send(input logic [7:0] op);
    return (op == OP_S) || (op == OP_I);
  endfunction

  // Response bits collected after the count
  function automatic logic op_recv(input logic [7:0] op);
    return (op == OP_G) || (op == OP_O);
  endfunction

endpackage

// File: rtl/tx_byte_hs.sv
// Single-byte handshake with the UART TX: wait for idle, raise start with
// the byte, drop start once the TX goes busy, finish when it is idle again.
// 'done' is combinational so the caller can advance on the completing edge.
module tx_byte_hs
  import cmd_proto_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       abort,
  input  logic       tx_ready_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       done
);

  hs_state_e st, st_nx;

  // State register; abort drops any byte in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      st <= HS_IDLE;
    else if (abort) st <= HS_IDLE;
    else            st <= st_nx;
  end

  // Next-state logic following the TX ready level
  always_comb begin
    st_nx = st;
    case (st)
      HS_IDLE:  if (go && tx_ready_i) st_nx = HS_START;
      HS_START: if (!tx_ready_i)      st_nx = HS_BUSY;
      HS_BUSY:  if (tx_ready_i)       st_nx = HS_IDLE;
      default:                        st_nx = HS_IDLE;
    endcase
  end

  // Completion strobe: TX back to idle after our byte
  always_comb begin
    done = (st == HS_BUSY) && tx_ready_i;
  end

  // Registered start/data; data holds its last value between bytes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else if (abort) begin
      tx_start_o <= 1'b0;
    end else if (st == HS_IDLE && go && tx_ready_i) begin
      tx_start_o <= 1'b1;
      tx_data_o  <= tx_byte;
    end else if (st == HS_START && !tx_ready_i) begin
      tx_start_o <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_issuer.sv
// Command issuer: turns a request (opcode, count, payload) into a byte
// stream to the UART TX and, for g/o, collects '0'/'1' response bytes.
// Optional response/handshake watchdog enabled by macro CMD_ISSUER_TIMEOUT_EN.
// MAXBITS must be >= 2 and $clog2(MAXBITS)+1 <= 16.
module cmd_issuer
  import cmd_proto_pkg::*;
#(
  parameter int MAXBITS     = 32,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [7:0]         req_op_i,
  input  logic [15:0]        req_count_i,
  input  logic [MAXBITS-1:0] req_bits_i,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_ready_i,
  input  logic [7:0]         rx_data,
  input  logic               new_rx_data,
  output logic               rsp_valid_o,
  output logic [MAXBITS-1:0] rsp_bits_o,
  output logic               err_o
);

  localparam int XW = $clog2(MAXBITS);  // bit-select width
  localparam int IW = XW + 1;           // index can reach MAXBITS

  cmd_state_e         state, state_nx;
  logic [7:0]         op_q;
  logic [15:0]        cnt_q;
  logic [MAXBITS-1:0] bits_q;
  logic [IW-1:0]      idx_q, idx_inc;
  logic               idx_last;
  logic               accept, req_ok, cnt_nz, cnt_fit;
  logic               rx_bit, rx_bad;
  logic               hs_go, hs_done, wd_hit;
  logic [7:0]         hs_byte;

  // Request legality and shared datapath terms
  always_comb begin
    cnt_nz   = (req_count_i != 16'h0);
    cnt_fit  = ({16'h0, req_count_i} <= 32'(MAXBITS));
    req_ok   = op_single(req_op_i)
             | ((req_op_i == OP_E) & cnt_nz)
             | (op_bitcount(req_op_i) & cnt_nz & cnt_fit);
    accept   = req_valid_i && (state == IDLE);
    idx_inc  = idx_q + IW'(1);
    idx_last = ({{(16-IW){1'b0}}, idx_inc} == cnt_q);
    rx_bit   = new_rx_data && (rx_data == CH_0 || rx_data == CH_1);
    rx_bad   = new_rx_data && !rx_bit;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; watchdog expiry overrides everything
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept && req_ok) state_nx = SEND_OP;
      SEND_OP:   if (hs_done) state_nx = op_single(op_q) ? DONE : SEND_CHI;
      SEND_CHI:  if (hs_done) state_nx = SEND_CLO;
      SEND_CLO:  if (hs_done) state_nx = op_send(op_q) ? SEND_BITS :
                                         op_recv(op_q) ? RECV_BITS : DONE;
      SEND_BITS: if (hs_done && idx_last) state_nx = DONE;
      RECV_BITS: begin
        if (rx_bad)                 state_nx = IDLE;
        else if (rx_bit && idx_last) state_nx = DONE;
      end
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (wd_hit) state_nx = IDLE;
  end

  // State-decoded outputs and the byte offered to the handshake
  always_comb begin
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == DONE);
    hs_go       = 1'b0;
    hs_byte     = 8'h00;
    case (state)
      SEND_OP:   begin hs_go = 1'b1; hs_byte = op_q;         end
      SEND_CHI:  begin hs_go = 1'b1; hs_byte = cnt_q[15:8];  end
      SEND_CLO:  begin hs_go = 1'b1; hs_byte = cnt_q[7:0];   end
      SEND_BITS: begin
        hs_go   = 1'b1;
        hs_byte = bits_q[idx_q[XW-1:0]] ? CH_1 : CH_0;
      end
      default: ;
    endcase
  end

  // Request capture, bit index, response bits and error strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q       <= 8'h00;
      cnt_q      <= 16'h0;
      bits_q     <= '0;
      idx_q      <= '0;
      rsp_bits_o <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (wd_hit) begin
        err_o <= 1'b1;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (req_ok) begin
              op_q       <= req_op_i;
              cnt_q      <= req_count_i;
              bits_q     <= req_bits_i;
              idx_q      <= '0;
              rsp_bits_o <= '0;
            end else begin
              err_o <= 1'b1;
            end
          end
          SEND_BITS: if (hs_done) idx_q <= idx_inc;
          RECV_BITS: begin
            if (rx_bad) begin
              err_o <= 1'b1;
            end else if (rx_bit) begin
              rsp_bits_o[idx_q[XW-1:0]] <= (rx_data == CH_1);
              idx_q                     <= idx_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  tx_byte_hs u_hs (
    .clk        (clk),
    .rstn       (rstn),
    .go         (hs_go),
    .tx_byte    (hs_byte),
    .abort      (wd_hit),
    .tx_ready_i (tx_ready_i),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .done       (hs_done)
  );

`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_active, wd_kick;

  always_comb begin
    wd_active = (state == SEND_OP) || (state == SEND_CHI) || (state == SEND_CLO) ||
                (state == SEND_BITS) || (state == RECV_BITS);
    wd_kick   = hs_done || ((state == RECV_BITS) && rx_bit);
    wd_hit    = wd_active && !wd_kick && (wd_cnt == WW'(TIMEOUT_CYC - 1));
  end

  // Watchdog: counts waiting cycles, restarts on every byte or bit of progress
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              wd_cnt <= '0;
    else if (!wd_active || wd_kick || wd_hit) wd_cnt <= '0;
    else                                    wd_cnt <= wd_cnt + WW'(1);
  end
`else
  assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed, table-driven bench for cmd_issuer with a behavioural UART TX
// model and hand-written reset / watchdog sequences.
module tb_cmd_issuer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_op_i = 8'h00;
  logic [15:0] req_count_i = 16'h0;
  logic [31:0] req_bits_i = 32'h0;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        new_rx_data = 1'b0;
  logic        rsp_valid_o;
  logic [31:0] rsp_bits_o;
  logic        err_o;

  cmd_issuer #(.MAXBITS(32), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_count_i(req_count_i), .req_bits_i(req_bits_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .rx_data(rx_data), .new_rx_data(new_rx_data),
    .rsp_valid_o(rsp_valid_o), .rsp_bits_o(rsp_bits_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  logic [7:0]  txq[$];
  int          last_rise = 0;
  int          rsp_cnt = 0, err_cnt = 0;
  logic [31:0] rsp_cap = 32'h0;

  // UART TX model: takes the byte, stays busy 3 cycles, then idle again
  initial forever begin
    @(negedge clk);
    if (tx_start_o) begin
      txq.push_back(tx_data_o);
      tx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      tx_ready_i = 1'b1;
      last_rise  = cyc;
    end
  end

  // Response / error pulse monitor
  initial forever begin
    @(negedge clk);
    if (rsp_valid_o) begin rsp_cnt++; rsp_cap = rsp_bits_o; end
    if (err_o) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]       op;
    logic [15:0]      cnt;
    logic [31:0]      bits;
    logic [31:0]      rxb;
    int               rxn;
    int               bad;
    int               txn;
    logic [0:7][7:0]  tx;
    int               rsp;
    int               err;
    logic [31:0]      rspb;
  } vec_t;

  function automatic vec_t mk(logic [7:0] op, logic [15:0] cnt, logic [31:0] bits,
                              logic [31:0] rxb, int rxn, int bad, int txn,
                              logic [63:0] tx, int rsp, int err, logic [31:0] rspb);
    vec_t v;
    v.op = op; v.cnt = cnt; v.bits = bits; v.rxb = rxb; v.rxn = rxn; v.bad = bad;
    v.txn = txn; v.tx = tx; v.rsp = rsp; v.err = err; v.rspb = rspb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_req(logic [7:0] op, logic [15:0] cnt, logic [31:0] bits);
    @(negedge clk);
    req_op_i = op; req_count_i = cnt; req_bits_i = bits; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] ch);
    @(negedge clk);
    rx_data = ch; new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic wait_end(int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rsp_cnt + err_cnt > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tx(int n, int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (txq.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_obs();
    txq.delete(); rsp_cnt = 0; err_cnt = 0; rsp_cap = 32'h0;
  endtask

  task automatic run_vec(vec_t v, int k);
    bit ok;
    logic [7:0] ch;
    clear_obs();
    do_req(v.op, v.cnt, v.bits);
    if (v.rxn > 0) begin
      wait_tx(3, 200, ok);
      chk($sformatf("v%0d tx_header_seen", k), 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      for (int i = 0; i < v.rxn; i++) begin
        if (i == v.bad) ch = "x";
        else            ch = v.rxb[i] ? "1" : "0";
        send_rx(ch);
      end
    end
    wait_end(500, ok);
    chk($sformatf("v%0d completes", k), 32'(ok), 32'd1);
    repeat (8) @(negedge clk);
    chk($sformatf("v%0d tx_count", k), 32'(txq.size()), 32'(v.txn));
    for (int j = 0; j < v.txn && j < txq.size(); j++)
      chk($sformatf("v%0d tx_byte%0d", k, j), 32'(txq[j]), 32'(v.tx[j]));
    chk($sformatf("v%0d rsp_valid_pulses", k), 32'(rsp_cnt), 32'(v.rsp));
    chk($sformatf("v%0d err_pulses", k), 32'(err_cnt), 32'(v.err));
    if (v.rsp > 0) chk($sformatf("v%0d rsp_bits", k), rsp_cap, v.rspb);
    chk($sformatf("v%0d req_ready", k), 32'(req_ready_o), 32'd1);
  endtask

  vec_t vt[17];

  initial begin
    bit ok;
    int t0;

    vt[0]  = mk("i", 16'd3,  32'b101, 32'h0, 0, -1, 6,
                {"i", 8'h00, 8'h03, "1", "0", "1", 16'h0}, 1, 0, 32'h0);
    vt[1]  = mk("g", 16'd4,  32'h0, 32'b1011, 4, -1, 3,
                {"g", 8'h00, 8'h04, 40'h0}, 1, 0, 32'h0000_000B);
    vt[2]  = mk("o", 16'd0,  32'h0, 32'h0, 0, -1, 0, 64'h0, 0, 1, 32'h0);
    vt[3]  = mk("o", 16'd33, 32'h0, 32'h0, 0, -1, 0, 64'h0, 0, 1, 32'h0);
    vt[4]  = mk("g", 16'd2,  32'h0, 32'h1, 2, 1, 3,
                {"g", 8'h00, 8'h02, 40'h0}, 0, 1, 32'h0);
    vt[5]  = mk("r", 16'd0,  32'h0, 32'h0, 0, -1, 1, {"r", 56'h0}, 1, 0, 32'h0);
    vt[6]  = mk("f", 16'd7,  32'h0, 32'h0, 0, -1, 1, {"f", 56'h0}, 1, 0, 32'h0);
    vt[7]  = mk("p", 16'd0,  32'h0, 32'h0, 0, -1, 1, {"p", 56'h0}, 1, 0, 32'h0);
    vt[8]  = mk("e", 16'h1234, 32'h0, 32'h0, 0, -1, 3,
                {"e", 8'h12, 8'h34, 40'h0}, 1, 0, 32'h0);
    vt[9]  = mk("e", 16'd0,  32'h0, 32'h0, 0, -1, 0, 64'h0, 0, 1, 32'h0);
    vt[10] = mk("z", 16'd1,  32'h0, 32'h0, 0, -1, 0, 64'h0, 0, 1, 32'h0);
    vt[11] = mk("s", 16'd2,  32'b10, 32'h0, 0, -1, 5,
                {"s", 8'h00, 8'h02, "0", "1", 24'h0}, 1, 0, 32'h0);
    vt[12] = mk("g", 16'd32, 32'h0, 32'h8000_0001, 32, -1, 3,
                {"g", 8'h00, 8'h20, 40'h0}, 1, 0, 32'h8000_0001);
    vt[13] = mk("o", 16'd1,  32'h0, 32'h0, 1, -1, 3,
                {"o", 8'h00, 8'h01, 40'h0}, 1, 0, 32'h0);
    vt[14] = mk("i", 16'd1,  32'hFFFF_FFFE, 32'h0, 0, -1, 4,
                {"i", 8'h00, 8'h01, "0", 32'h0}, 1, 0, 32'h0);
    vt[15] = mk("e", 16'hFFFF, 32'h0, 32'h0, 0, -1, 3,
                {"e", 8'hFF, 8'hFF, 40'h0}, 1, 0, 32'h0);
    vt[16] = mk("s", 16'd0,  32'h0, 32'h0, 0, -1, 0, 64'h0, 0, 1, 32'h0);

    // Reset values, during and right after reset
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_tx_start", 32'(tx_start_o), 32'd0);
    chk("rel_tx_data", 32'(tx_data_o), 32'd0);
    chk("rel_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rel_rsp_bits", rsp_bits_o, 32'd0);
    chk("rel_err", 32'(err_o), 32'd0);
    chk("rel_req_ready", 32'(req_ready_o), 32'd1);

    for (int k = 0; k < 17; k++) run_vec(vt[k], k);

    // Reset while the count high byte of 'e' 0x1234 is on the wire
    clear_obs();
    do_req("e", 16'h1234, 32'h0);
    wait_tx(2, 200, ok);
    chk("mid_rst_reached_chi", 32'(ok), 32'd1);
    chk("mid_rst_chi_byte", 32'(txq.size() > 1 ? txq[1] : 8'h00), 32'h12);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tx_start", 32'(tx_start_o), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_more_tx", 32'(txq.size()), 32'd2);
    chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'd0);
    clear_obs();
    do_req("r", 16'h0, 32'h0);
    wait_end(200, ok);
    repeat (6) @(negedge clk);
    chk("post_rst_r_done", 32'(ok), 32'd1);
    chk("post_rst_r_count", 32'(txq.size()), 32'd1);
    chk("post_rst_r_byte", 32'(txq.size() > 0 ? txq[0] : 8'h00), 32'h72);
    chk("post_rst_r_rsp", 32'(rsp_cnt), 32'd1);

`ifdef CMD_ISSUER_TIMEOUT_EN
    // Watchdog: 'g' with no response bytes
    clear_obs();
    do_req("g", 16'd4, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err_o) begin ok = 1'b1; break; end
    end
    t0 = cyc - last_rise;
    chk("wd_err_seen", 32'(ok), 32'd1);
    chk("wd_err_latency", 32'(t0), 32'd101);
    chk("wd_tx_count", 32'(txq.size()), 32'd3);
    repeat (4) @(negedge clk);
    chk("wd_err_single", 32'(err_cnt), 32'd1);
    chk("wd_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("wd_idle", 32'(req_ready_o), 32'd1);
    chk("wd_tx_start", 32'(tx_start_o), 32'd0);
`else
    // Without the watchdog a silent 'g' waits forever
    clear_obs();
    do_req("g", 16'd4, 32'h0);
    repeat (300) @(negedge clk);
    t0 = 0;
    chk("nowd_no_err", 32'(err_cnt), 32'd0);
    chk("nowd_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("nowd_still_busy", 32'(req_ready_o), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("nowd_rst_idle", 32'(req_ready_o), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
